// File: rtl/nn_pkg.sv
// Shared types and width helpers for the layer MAC sequencer and its neuron datapaths.
package nn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MAC,
      S_WRITE,
      S_DONE
   } state_e;

   function automatic int prod_w(input int qm, input int qn, input int wm, input int wn);
      return qm + qn + wm + wn;
   endfunction

   function automatic int guard_w(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic int acc_w(input int n, input int qm, input int qn, input int wm, input int wn);
      return prod_w(qm, qn, wm, wn) + guard_w(n);
   endfunction

   // Keep counters at least one bit wide for degenerate sizes.
   function automatic int addr_w(input int m);
      return (m > 2) ? $clog2(m - 1) : 1;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int sat_max(input int qm, input int qn);
      return (1 << (qm + qn - 1)) - 1;
   endfunction

endpackage

// File: rtl/neuron_mac.sv
// One neuron: serial multiply-accumulate, bias add, ReLU and saturation to the data format.
module neuron_mac
   import nn_pkg::*;
#(
   parameter int N  = 2,
   parameter int QM = 3,
   parameter int QN = 5,
   parameter int WM = 3,
   parameter int WN = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     en_i,
   input  logic                     res_ld_i,
   input  logic signed [QM+QN-1:0]  in_i,
   input  logic signed [WM+WN-1:0]  w_i,
   input  logic signed [QM+QN-1:0]  bias_i,
   output logic signed [QM+QN-1:0]  res_o
);

   localparam int DW = QM + QN;
   localparam int PW = prod_w(QM, QN, WM, WN);
   localparam int AW = acc_w(N, QM, QN, WM, WN);
   localparam logic signed [AW-1:0] SAT = AW'(sat_max(QM, QN));

   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prod_x, bias_x, acc_q, acc_d, sum, shr;
   logic signed [DW-1:0] act, res_q;

   assign prod   = in_i * w_i;
   assign prod_x = prod;
   assign bias_x = bias_i;

   // Result is formed from acc_d so the final product lands in the same edge.
   always_comb begin
      acc_d = acc_q;
      if (clear_i)   acc_d = '0;
      else if (en_i) acc_d = acc_q + prod_x;
      sum = acc_d + (bias_x <<< WN);
      shr = sum >>> WN;
      if (sum < 0)        act = '0;
      else if (shr > SAT) act = SAT[DW-1:0];
      else                act = shr[DW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         res_q <= '0;
      end else begin
         acc_q <= acc_d;
         if (res_ld_i) res_q <= act;
      end
   end

   assign res_o = res_q;

endmodule

// File: rtl/layer_mac_sequencer.sv
// Walks the network layer by layer: load operands, run N serial MAC steps, write results back.
module layer_mac_sequencer
   import nn_pkg::*;
#(
   parameter int M  = 3,
   parameter int N  = 2,
   parameter int QM = 3,
   parameter int QN = 5,
   parameter int WM = 3,
   parameter int WN = 5
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   output logic                                     busy,
   output logic                                     done,
   output logic signed [N-1:0][QM+QN-1:0]           y,
   output logic                                     read_en,
   output logic [addr_w(M)-1:0]                     layer_addr,
   input  logic signed [N-1:0][QM+QN-1:0]           inputs,
   input  logic signed [N-1:0][N-1:0][WM+WN-1:0]    weights,
   input  logic signed [N-1:0][QM+QN-1:0]           bias,
   output logic                                     write_en,
   output logic signed [N-1:0][QM+QN-1:0]           result
);

   localparam int DW = QM + QN;
   localparam int WW = WM + WN;
   localparam int LW = addr_w(M);
   localparam int KW = cnt_w(N);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   localparam logic [LW-1:0] L_LAST = LW'(M - 2);

   state_e                       state_q;
   logic [LW-1:0]                layer_q;
   logic [KW-1:0]                k_q;
   logic                         busy_q, done_q, rd_q, wr_q;
   logic [N-1:0][DW-1:0]         in_q, b_q, y_q, res_w;
   logic [N-1:0][N-1:0][WW-1:0]  w_q;
   logic                         mac_clr, mac_en, res_ld;

   assign mac_clr = (state_q == S_LOAD);
   assign mac_en  = (state_q == S_MAC);
   assign res_ld  = mac_en && (k_q == K_LAST);

   // layer_q doubles as layer_addr; it is zeroed on the way into DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         layer_q <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         in_q    <= '0;
         w_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
      end else begin
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               state_q <= S_LOAD;
               layer_q <= '0;
               busy_q  <= 1'b1;
               rd_q    <= 1'b1;
            end
            S_LOAD: begin
               in_q    <= inputs;
               w_q     <= weights;
               b_q     <= bias;
               k_q     <= '0;
               state_q <= S_MAC;
            end
            S_MAC: begin
               if (k_q == K_LAST) begin
                  state_q <= S_WRITE;
                  wr_q    <= 1'b1;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            S_WRITE: begin
               if (layer_q == L_LAST) begin
                  state_q <= S_DONE;
                  y_q     <= res_w;
                  done_q  <= 1'b1;
                  layer_q <= '0;
               end else begin
                  state_q <= S_LOAD;
                  layer_q <= layer_q + 1'b1;
                  rd_q    <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_nrn
      neuron_mac #(.N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) u_nrn (
         .clk      (clk),
         .rst      (rst),
         .clear_i  (mac_clr),
         .en_i     (mac_en),
         .res_ld_i (res_ld),
         .in_i     (in_q[k_q]),
         .w_i      (w_q[j][k_q]),
         .bias_i   (b_q[j]),
         .res_o    (res_w[j])
      );
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign read_en    = rd_q;
   assign write_en   = wr_q;
   assign layer_addr = layer_q;
   assign result     = res_w;
   assign y          = y_q;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer: a two-layer memory model and hand-computed vectors.
module tb_layer_mac_sequencer;

   localparam int M  = 3;
   localparam int N  = 2;
   localparam int DW = 8;
   localparam int WW = 8;

   typedef logic [N-1:0][DW-1:0]        dvec_t;
   typedef logic [N-1:0][N-1:0][WW-1:0] wmat_t;

   logic  clk = 1'b0;
   logic  rst, start;
   logic  busy, done, read_en, write_en;
   logic  [0:0] layer_addr;
   dvec_t y, result, inputs, bias;
   wmat_t weights;

   dvec_t x0, b0, b1, r0_q;
   wmat_t w0, w1;

   int n_chk = 0;
   int n_err = 0;

   layer_mac_sequencer #(.M(M), .N(N), .QM(3), .QN(5), .WM(3), .WN(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .y          (y),
      .read_en    (read_en),
      .layer_addr (layer_addr),
      .inputs     (inputs),
      .weights    (weights),
      .bias       (bias),
      .write_en   (write_en),
      .result     (result)
   );

   always #5 clk = ~clk;

   // Memory: layer 1 inputs are whatever layer 0 wrote back.
   always_comb begin
      inputs  = (layer_addr == 1'b0) ? x0 : r0_q;
      weights = (layer_addr == 1'b0) ? w0 : w1;
      bias    = (layer_addr == 1'b0) ? b0 : b1;
   end

   always @(negedge clk) begin
      if (read_en && layer_addr == 1'b0) r0_q <= '0;
      if (write_en && layer_addr == 1'b0) r0_q <= result;
   end

   function automatic dvec_t dv(input int a0, input int a1);
      dvec_t v;
      v[0] = DW'(a0);
      v[1] = DW'(a1);
      return v;
   endfunction

   function automatic wmat_t wm(input int w00, input int w01, input int w10, input int w11);
      wmat_t v;
      v[0][0] = WW'(w00);
      v[0][1] = WW'(w01);
      v[1][0] = WW'(w10);
      v[1][1] = WW'(w11);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // e counts edges after the one that samples start; LOAD is e=0, DONE is e=8.
   task automatic run_net(input string tag, input dvec_t er0, input dvec_t ey);
      logic [8:0] rd_m, wr_m, dn_m, bz_m, la_m;
      rd_m = '0; wr_m = '0; dn_m = '0; bz_m = '0; la_m = '0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int e = 0; e <= 8; e++) begin
         @(negedge clk);
         if (e == 0) start = 1'b0;
         rd_m[e] = read_en;
         wr_m[e] = write_en;
         dn_m[e] = done;
         bz_m[e] = busy;
         la_m[e] = layer_addr[0];
         if (e == 2) start = 1'b1;
         if (e == 3) start = 1'b0;
      end
      chk({tag, "_rd"},   64'(rd_m), 64'h011);
      chk({tag, "_wr"},   64'(wr_m), 64'h088);
      chk({tag, "_done"}, 64'(dn_m), 64'h100);
      chk({tag, "_busy"}, 64'(bz_m), 64'h1FF);
      chk({tag, "_addr"}, 64'(la_m), 64'h0F0);
      chk({tag, "_res0"}, 64'(r0_q), 64'(er0));
      chk({tag, "_y"},    64'(y),    64'(ey));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr_cnt;
      rst = 1'b1; start = 1'b0;
      x0 = '0; b0 = '0; b1 = '0; w0 = '0; w1 = '0;
      repeat (2) @(negedge clk);
      chk("reset_ctl", 64'({busy, done, read_en, write_en, layer_addr}), 64'h0);
      chk("reset_res", 64'(result), 64'h0);
      chk("reset_y",   64'(y),      64'h0);
      rst = 1'b0;

      // 1.0 * 0.5 * 2 = 1.0 on both layers
      x0 = dv(32, 32); w0 = wm(16, 16, 16, 16); b0 = dv(0, 0);
      w1 = wm(16, 16, 16, 16); b1 = dv(0, 0);
      run_net("nominal", dv(32, 32), dv(32, 32));

      // negative layer-0 sums clamp to 0; layer 1 output is its bias
      w0 = wm(-32, -32, -32, -32); b1 = dv(8, 8);
      run_net("relu", dv(0, 0), dv(8, 8));

      x0 = dv(96, 96); w0 = wm(96, 96, 96, 96); w1 = wm(96, 96, 96, 96);
      b0 = dv(0, 0); b1 = dv(0, 0);
      run_net("sat", dv(127, 127), dv(127, 127));

      // mixed signs; layer-1 neuron 1 gives 13.5 truncated to 13
      x0 = dv(32, -16); w0 = wm(32, 16, -32, 48); b0 = dv(5, -2);
      w1 = wm(32, 0, 16, 16); b1 = dv(0, -1);
      run_net("mixed", dv(29, 0), dv(29, 13));

      @(negedge clk);
      chk("idle_after", 64'({busy, done}), 64'h0);

      // reset in the middle of layer-1 MAC
      x0 = dv(32, 32); w0 = wm(16, 16, 16, 16); b0 = dv(0, 0);
      w1 = wm(16, 16, 16, 16); b1 = dv(0, 0);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", 64'({busy, layer_addr}), 64'h3);
      rst = 1'b1;
      #1;
      chk("midrst_ctl", 64'({busy, done, read_en, write_en, layer_addr}), 64'h0);
      chk("midrst_res", 64'(result), 64'h0);
      chk("midrst_y",   64'(y),      64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wr_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (write_en) wr_cnt++;
      end
      chk("post_rst_wr", 64'(wr_cnt), 64'h0);

      run_net("after_rst", dv(32, 32), dv(32, 32));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/layer_mac_sequencer.md
# layer_mac_sequencer

Initiator for the N-neuron layer memory: it walks an (M-1)-layer fully connected network one layer at a time. For each layer it reads the layer's inputs, weights and bias from the memory and runs N parallel neurons serially over the N inputs. It then applies bias, ReLU and saturation and writes the N results back to the memory. The sequencer sits between the testbench/top-level start control and the memory's `read_en`/`layer_addr`/`write_en`/`result` port group.

## Interface
- `M`, 3: number of network layers including the input layer; M-1 computed layers.
- `N`, 2: neurons per layer, which is also the number of inputs per neuron.
- `QM`, 3: integer bits of data (inputs, bias, results).
- `QN`, 5: fraction bits of data.
- `WM`, 3: integer bits of weights.
- `WN`, 5: fraction bits of weights.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to run the whole network; sampled only in IDLE.
- `busy`  out  1  high in LOAD, MAC, WRITE and DONE.
- `done`  out  1  one-cycle pulse after the last layer is written.
- `y`  out  signed [QM+QN-1:0] x N  final-layer results; registered; hold until the next `done` or reset.
- `read_en`  out  1  memory read strobe.
- `layer_addr`  out  [$clog2(M-1)-1:0]  layer being read or computed.
- `inputs`  in  signed [QM+QN-1:0] x N  from memory, valid while `read_en` is high.
- `weights`  in  signed [WM+WN-1:0] x N x N  indexed [neuron][input].
- `bias`  in  signed [QM+QN-1:0] x N.
- `write_en`  out  1  memory write strobe.
- `result`  out  signed [QM+QN-1:0] x N  registered; valid while `write_en` is high.

## Operation
- FSM states: IDLE, LOAD, MAC, WRITE, DONE.
- IDLE:
  - `start` moves the FSM to LOAD with layer=0; otherwise it stays in IDLE.
- LOAD, one cycle:
  - `read_en`=1 and `layer_addr`=layer.
  - Capture `inputs`, `weights` and `bias` into local registers.
  - Clear all accumulators and set k=0.
- MAC, N cycles, k=0..N-1:
  - For every neuron j: acc[j] += in[k]*w[j][k].
  - Leave MAC after k=N-1.
- WRITE, one cycle:
  - `write_en`=1 and `layer_addr`=layer; `result` is already registered.
  - If layer==M-2, go to DONE and load `y` <= `result`.
  - Otherwise layer++ and go to LOAD.
- DONE, one cycle:
  - `done`=1, then return to IDLE.
- Arithmetic:
  - Each product is QM+QN+WM+WN bits with QN+WN fraction bits.
  - The accumulator adds $clog2(N)+1 guard bits.
  - Bias is sign-extended and shifted left by WN before it is added.
- Activation:
  - A negative sum gives 0 (ReLU).
  - Otherwise shift right arithmetically by WN, truncating.
  - Saturate to 2^(QM+QN-1)-1 if the value exceeds it.
  - `result` is never negative.
- `start` while busy is ignored; there is no queuing.
- `read_en` and `write_en` are never high in the same cycle, and each is high for exactly one cycle per layer.
- `layer_addr` is 0 in IDLE and DONE.

## Timing
- Reset values:
  - FSM = IDLE, layer = 0, k = 0.
  - `busy`, `done`, `read_en`, `write_en` = 0.
  - `layer_addr` = 0.
  - `result`, `y` and all accumulators = 0.
- Per-layer latency is N+2 cycles (1 LOAD + N MAC + 1 WRITE).
- `done` is high in the cycle beginning (M-1)(N+2) rising edges after the edge that samples `start`.
- Back-to-back runs are possible: `start` high in the cycle after `done` is accepted, because IDLE is re-entered.
- Reset asserted mid-run returns all state and outputs to reset values immediately; `write_en` must not pulse afterwards.
- `y` changes only at the WRITE to DONE transition.

## Structure
- Shared package `nn_pkg` holds:
  - the FSM state enum;
  - width helper constants/functions for product, accumulator and guard widths;
  - the saturation maximum.
- Natural sub-module: `neuron_mac`, one instance per neuron via generate.
  - Contains the accumulator, bias add, ReLU and saturation.
  - Controlled by `clear`/`en` from the sequencer.

## Test plan
Default parameters apply (M=3, N=2, QM=3, QN=5, WM=3, WN=5), so 1.0 = 32.
- Nominal two-layer run:
  - Stimulus: x=[32,32], all w=16, b=0.
  - Response: layer-0 `result`=[32,32]; `y`=[32,32]; `done` 8 cycles after the `start` edge.
- ReLU:
  - Stimulus: x=[32,32], layer-0 w all -32, b=0.
  - Response: layer-0 `result`=[0,0]; `y`=[b1, b1] with layer-1 b=[8,8], giving `y`=[8,8].
- Saturation:
  - Stimulus: x=[96,96], all w=96.
  - Response: `result`=[127,127] on both layers.
- Handshake:
  - `read_en` pulses at cycles 1 and 5 and `write_en` at cycles 4 and 8 relative to the start edge.
  - `layer_addr` is 0 then 1; `start` pulsed during busy has no effect.
- Reset mid-MAC of layer 1:
  - All outputs are 0 on assertion and no further `write_en` pulses occur.
  - A new `start` then completes normally.
